// File: rtl/rf_writeback_queue_if.sv
// Handshake and forwarding bundle between the writeback
// queue, its producer, and the register file.
interface rf_writeback_queue_if #(
    parameter int AW = 2
);
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_reg;
    logic [31:0]   in_data;
    logic          drain_en;
    logic          write;
    logic [4:0]    writereg;
    logic [31:0]   data;
    logic [4:0]    reg1;
    logic [4:0]    reg2;
    logic          fwd1_hit;
    logic [31:0]   fwd1_data;
    logic          fwd2_hit;
    logic [31:0]   fwd2_data;
    logic [AW:0]   count;

    modport master (
        output in_valid, in_reg, in_data, drain_en, reg1, reg2,
        input  in_ready, write, writereg, data,
        input  fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count
    );

    modport slave (
        input  in_valid, in_reg, in_data, drain_en, reg1, reg2,
        output in_ready, write, writereg, data,
        output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count
    );
endinterface

// File: rtl/rf_writeback_queue.sv
// Register-file writeback queue: FIFO of pending writes
// drained one per cycle, with newest-value read forwarding.
module rf_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rf_writeback_queue_if.slave    bus
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [4:0]    ent_reg  [DEPTH];
    logic [31:0]   ent_data [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          push;
    logic          pop;
    logic          busy;
    logic [32:0]   f1;
    logic [32:0]   f2;

    assign busy         = (cnt != '0);
    assign bus.in_ready = (cnt < FULL);
    assign push         = bus.in_valid & bus.in_ready
                        & (bus.in_reg != 5'd0);
    // No strobe while reset is held, so a discarded entry never lands.
    assign bus.write    = rst_n & bus.drain_en & busy;
    assign pop          = bus.write;
    assign bus.writereg = busy ? ent_reg[rp]  : 5'd0;
    assign bus.data     = busy ? ent_data[rp] : 32'd0;
    assign bus.count    = cnt;

    // Scan oldest to newest; the last match is the newest value.
    function automatic logic [32:0] lookup(input logic [4:0] a);
        logic [32:0]   r;
        logic [AW-1:0] idx;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rp + AW'(i);
            if (((AW+1)'(i) < cnt) && (a != 5'd0)
                && (ent_reg[idx] == a))
                r = {1'b1, ent_data[idx]};
        end
        return r;
    endfunction

    // Forwarding lookup for both read ports.
    always_comb begin
        f1 = lookup(bus.reg1);
        f2 = lookup(bus.reg2);
    end

    assign bus.fwd1_hit  = f1[32];
    assign bus.fwd1_data = f1[31:0];
    assign bus.fwd2_hit  = f2[32];
    assign bus.fwd2_data = f2[31:0];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_reg[wp]  <= bus.in_reg;
            ent_data[wp] <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Scoreboard bench for rf_writeback_queue: directed scenarios
// followed by random traffic against a queue-based model.
module tb_rf_writeback_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    typedef struct packed {
        logic [4:0]  rg;
        logic [31:0] dt;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;

    rf_writeback_queue_if #(.AW(AW)) bus();

    rf_writeback_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    ent_t pend[$];
    ent_t exp_q[$];
    ent_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [32:0] model_fwd(input logic [4:0] a);
        if (a == 5'd0)
            return '0;
        for (int i = pend.size() - 1; i >= 0; i--)
            if (pend[i].rg == a)
                return {1'b1, pend[i].dt};
        return '0;
    endfunction

    // Monitor: every register-file write must match the scoreboard head.
    always @(negedge clk) begin
        if (bus.write === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got reg %0d data %h expected none",
                         bus.writereg, bus.data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("writereg", 32'(bus.writereg), 32'(mon_e.rg));
                chk("wr_data", bus.data, mon_e.dt);
            end
        end
    end

    task automatic cyc(input logic v, input logic [4:0] r,
                       input logic [31:0] d, input logic de,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic rs);
        logic [32:0] f1;
        logic [32:0] f2;
        bit          acc;
        bus.in_valid = v;
        bus.in_reg   = r;
        bus.in_data  = d;
        bus.drain_en = de;
        bus.reg1     = a1;
        bus.reg2     = a2;
        rst_n        = rs;
        @(negedge clk);
        f1 = model_fwd(a1);
        f2 = model_fwd(a2);
        chk("count", 32'(bus.count), 32'(pend.size()));
        chk("in_ready", 32'(bus.in_ready), 32'(pend.size() < DEPTH));
        chk("write", 32'(bus.write), 32'(rs && de && pend.size() > 0));
        chk("fwd1_hit", 32'(bus.fwd1_hit), 32'(f1[32]));
        chk("fwd1_data", bus.fwd1_data, f1[31:0]);
        chk("fwd2_hit", 32'(bus.fwd2_hit), 32'(f2[32]));
        chk("fwd2_data", bus.fwd2_data, f2[31:0]);
        @(posedge clk);
        if (!rs) begin
            pend.delete();
            exp_q.delete();
        end else begin
            acc = v && (pend.size() < DEPTH);
            if (de && pend.size() > 0)
                void'(pend.pop_front());
            if (acc && r != 5'd0) begin
                pend.push_back(ent_t'{rg: r, dt: d});
                exp_q.push_back(ent_t'{rg: r, dt: d});
            end
        end
        #1;
    endtask

    task automatic idle(input logic de, input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 5'd0, 32'd0, de, 5'd3, 5'd4, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b1;
        bus.in_reg   = 5'd3;
        bus.in_data  = 32'd1;
        bus.drain_en = 1'b0;
        bus.reg1     = 5'd3;
        bus.reg2     = 5'd0;
        rst_n        = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b1, 5'd3, 32'd1, 1'b0, 5'd3, 5'd0, 1'b0);
        idle(1'b0, 2);

        cyc(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 5'd0, 1'b1);
        cyc(1'b1, 5'd5, 32'h22, 1'b0, 5'd3, 5'd0, 1'b1);
        cyc(1'b1, 5'd7, 32'h33, 1'b0, 5'd5, 5'd3, 1'b1);
        cyc(1'b1, 5'd9, 32'h44, 1'b0, 5'd7, 5'd5, 1'b1);
        cyc(1'b1, 5'd11, 32'h55, 1'b0, 5'd9, 5'd11, 1'b1);
        idle(1'b1, 5);

        cyc(1'b1, 5'd4, 32'hAAAA0000, 1'b0, 5'd4, 5'd6, 1'b1);
        cyc(1'b1, 5'd4, 32'hBBBB0001, 1'b0, 5'd4, 5'd6, 1'b1);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd4, 5'd6, 1'b1);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd6, 1'b1);
        idle(1'b1, 2);

        cyc(1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 5'd0, 1'b1);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 1'b1);

        for (int i = 1; i <= DEPTH; i++)
            cyc(1'b1, 5'(i), 32'(i * 16'h101), 1'b0, 5'd2, 5'd4, 1'b1);
        cyc(1'b1, 5'd20, 32'hF00D, 1'b1, 5'd20, 5'd1, 1'b1);
        cyc(1'b1, 5'd21, 32'hF00E, 1'b1, 5'd21, 5'd2, 1'b1);
        cyc(1'b1, 5'd22, 32'hF00F, 1'b1, 5'd22, 5'd3, 1'b1);
        idle(1'b1, 5);

        cyc(1'b1, 5'd6, 32'h61, 1'b0, 5'd6, 5'd0, 1'b1);
        cyc(1'b1, 5'd7, 32'h71, 1'b0, 5'd6, 5'd7, 1'b1);
        cyc(1'b1, 5'd8, 32'h81, 1'b0, 5'd8, 5'd7, 1'b1);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd8, 1'b0);
        cyc(1'b1, 5'd2, 32'h5, 1'b1, 5'd6, 5'd2, 1'b1);
        idle(1'b1, 3);

        for (int i = 0; i < 400; i++)
            cyc(1'b1 & ($urandom_range(3) != 0),
                5'($urandom_range(7)), $urandom,
                1'b1 & ($urandom_range(2) != 0),
                5'($urandom_range(7)), 5'($urandom_range(7)),
                1'b1 & ($urandom_range(63) != 0));

        for (int i = 0; i < 2 * DEPTH + 4; i++) begin
            if (exp_q.size() == 0)
                break;
            idle(1'b1, 1);
        end
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_writeback_queue.md
Name: rf_writeback_queue

Overview:
Buffers register-file write requests (destination index plus 32-bit result) from the execute/writeback side. It drains them one per cycle into the 32x32 register file's single write port (write/writereg/data). While results are pending it forwards the newest pending value for the two register-file read addresses, so consumers never read a stale register. It sits directly upstream of the register file write port.

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2.
AW, 2, pointer width, log2(DEPTH); must match DEPTH.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset; one clock; reset is synchronous and active-low
in_valid  input  1  producer presents a write request
in_ready  output  1  queue can accept; high iff count < DEPTH
in_reg  input  5  destination register index
in_data  input  32  result value
drain_en  input  1  register file may accept a write this cycle
write  output  1  write strobe to register file
writereg  output  5  write index to register file (queue head)
data  output  32  write data to register file (queue head)
reg1  input  5  read address 1, same value the register file sees
reg2  input  5  read address 2
fwd1_hit  output  1  a pending entry targets reg1
fwd1_data  output  32  newest pending value for reg1; 0 when no hit
fwd2_hit  output  1  a pending entry targets reg2
fwd2_data  output  32  newest pending value for reg2; 0 when no hit
count  output  AW+1  number of occupied entries, 0..DEPTH

Behaviour:
- Storage: circular buffer of DEPTH entries {reg[4:0], data[31:0]}; write pointer wp, read pointer rp, both AW bits wide, wrapping modulo DEPTH; count register AW+1 bits.
- Reset (rst_n low at a rising edge): wp=0, rp=0, count=0. Consequently write=0, in_ready=1, fwd*_hit=0, fwd*_data=0. Entry contents are don't-care. Reset mid-operation discards all pending entries; nothing is written to the register file during or after that edge.
- Accept: push = in_valid & in_ready & (in_reg != 0). Push stores the entry at wp, then wp+1.
- Register 0 is hardwired zero: in_valid & in_ready with in_reg==0 completes the handshake but enqueues nothing.
- Drain: write = drain_en & (count != 0), combinational. writereg/data always show the head entry at rp; they are 0 when count==0. On a rising edge with write=1 the head is consumed, rp+1. One entry per cycle maximum. Latency from accept to write is at least 1 cycle; an entry accepted at edge N can appear on write no earlier than the cycle after edge N.
- in_ready depends only on count (in_ready = count<DEPTH). A full queue does not accept in the same cycle it drains; no combinational path from drain_en to in_ready.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Forwarding (combinational): fwdN_hit=1 iff some occupied entry has reg==regN and regN!=0. fwdN_data is the data of the newest such entry, i.e. closest to wp-1 going backward. The incoming in_* request of the current cycle is not forwarded. The head entry being written this cycle is still forwarded, because the register file only updates at the edge.
- Ordering: entries leave in strict FIFO order. Multiple pending writes to the same register all reach the register file in order.
- No error outputs: pushing while full is blocked by in_ready; draining while empty is a no-op.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles with in_valid=1 -> count=0, write=0, in_ready=1, fwd1_hit=0. Release, no traffic -> state unchanged.
- Fill/drain order: drain_en=0, push (r3,0x11),(r5,0x22),(r7,0x33),(r9,0x44) -> count=4, in_ready=0. Set drain_en=1 -> writereg/data = 3/0x11, 5/0x22, 7/0x33, 9/0x44 on 4 consecutive cycles, then write=0, count=0.
- Forward newest: drain_en=0, push (r4,0xAAAA0000) then (r4,0xBBBB0001), reg1=4, reg2=6 -> fwd1_hit=1, fwd1_data=0xBBBB0001, fwd2_hit=0, fwd2_data=0.
- Register 0: push (r0,0xDEADBEEF) -> handshake completes, count stays 0, write never asserted. reg1=0 -> fwd1_hit=0.
- Full with simultaneous traffic: count=4, drain_en=1, in_valid=1 -> in_ready=0, one pop, count=3. Next cycle push+pop -> count stays 3, pointers wrap past DEPTH-1 with correct FIFO order.
- Reset mid-operation: 3 entries pending, assert rst_n=0 for one edge while drain_en=1 -> count=0, no write in any cycle after that edge, and a subsequent push (r2,0x5) is the next entry written.
